systolic_ctrl: RTL and testbench



---
 rtl/systolic_ctrl.sv | 149 ++++++++++++++
 tb/tb_systolic_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job sequencer for a size x size systolic multiply array.
// Walks LOAD -> COMPUTE -> OUTPUT -> CLEAR, driving FIFO enables, the PE
// enable, the result selects and a one-cycle accumulator clear. It carries
// no operand data.
module systolic_ctrl #(
  parameter int size = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_val,
  output logic                     in_rdy,
  output logic [size-1:0]          x_fifo_wen,
  output logic [size-1:0]          w_fifo_wen,
  output logic [size-1:0]          x_fifo_ren,
  output logic [size-1:0]          w_fifo_ren,
  input  logic [size-1:0]          x_fifo_full,
  input  logic [size-1:0]          w_fifo_full,
  input  logic [size-1:0]          x_fifo_empty,
  input  logic [size-1:0]          w_fifo_empty,
  output logic                     mac_en,
  output logic                     acc_clr,
  output logic [$clog2(size)-1:0]  out_rsel,
  output logic [$clog2(size)-1:0]  out_csel,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic                     busy,
  output logic                     err
);

  localparam int SEL_W = $clog2(size);
  localparam int K_W   = $clog2(3 * size);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(size - 1);
  localparam logic [K_W-1:0]   K_MAX   = K_W'(3 * size - 2);

  typedef enum logic [1:0] {
    S_LOAD,
    S_COMPUTE,
    S_OUTPUT,
    S_CLEAR
  } state_t;

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  beat_cnt;
  logic [SEL_W-1:0]  rsel, csel;
  logic [K_W-1:0]    k;
  logic              err_q;

  logic              in_rdy_c, out_val_c, mac_en_c, acc_clr_c, busy_c;
  logic [size-1:0]   wen_c, ren_c;
  logic              in_acc, out_acc, viol;

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  // Beat counter, compute cycle counter, result selects and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      k        <= '0;
      rsel     <= '0;
      csel     <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_q | viol;
      case (state)
        S_LOAD: begin
          if (in_acc) beat_cnt <= (beat_cnt == SEL_MAX) ? '0 : beat_cnt + SEL_W'(1);
        end
        S_COMPUTE: begin
          k <= (k == K_MAX) ? '0 : k + K_W'(1);
        end
        S_OUTPUT: begin
          if (out_acc) begin
            csel <= csel + SEL_W'(1);
            if (csel == SEL_MAX) rsel <= rsel + SEL_W'(1);
          end
        end
        S_CLEAR: begin
          rsel <= '0;
          csel <= '0;
        end
        default: ;
      endcase
    end
  end

  // Next-state and raw (pre-reset-gating) outputs.
  always_comb begin
    state_nxt = state;
    in_rdy_c  = 1'b0;
    out_val_c = 1'b0;
    mac_en_c  = 1'b0;
    acc_clr_c = 1'b0;
    busy_c    = 1'b1;
    wen_c     = '0;
    ren_c     = '0;
    in_acc    = 1'b0;
    out_acc   = 1'b0;
    case (state)
      S_LOAD: begin
        busy_c   = 1'b0;
        in_rdy_c = 1'b1;
        in_acc   = in_val;
        wen_c    = {size{in_val}};
        if (in_val && beat_cnt == SEL_MAX) state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        mac_en_c = 1'b1;
        // Wavefront skew: lane i reads during k = i .. i+size-1.
        for (int i = 0; i < size; i++) begin
          ren_c[i] = (k >= K_W'(i)) && (k <= K_W'(i + size - 1));
        end
        if (k == K_MAX) state_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        out_val_c = 1'b1;
        out_acc   = out_rdy;
        if (out_rdy && rsel == SEL_MAX && csel == SEL_MAX) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        acc_clr_c = 1'b1;
        state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // Every output is held at zero while reset is asserted.
  assign in_rdy     = in_rdy_c  & ~rst;
  assign out_val    = out_val_c & ~rst;
  assign mac_en     = mac_en_c  & ~rst;
  assign acc_clr    = acc_clr_c & ~rst;
  assign busy       = busy_c    & ~rst;
  assign x_fifo_wen = wen_c & {size{~rst}};
  assign w_fifo_wen = wen_c & {size{~rst}};
  assign x_fifo_ren = ren_c & {size{~rst}};
  assign w_fifo_ren = ren_c & {size{~rst}};
  assign out_rsel   = rst ? '0 : rsel;
  assign out_csel   = rst ? '0 : csel;

  // A violation is flagged in the cycle it happens and remembered after.
  assign viol = |(x_fifo_wen & x_fifo_full)  | |(w_fifo_wen & w_fifo_full) |
                |(x_fifo_ren & x_fifo_empty) | |(w_fifo_ren & w_fifo_empty);
  assign err  = (err_q | viol) & ~rst;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl at size=4. Inputs change 1ns after the
// rising edge; outputs are sampled at the falling edge.
module tb_systolic_ctrl;

  localparam int SZ = 4;

  logic          clk = 1'b0;
  logic          rst, in_val, out_rdy;
  logic          in_rdy, mac_en, acc_clr, out_val, busy, err;
  logic [SZ-1:0] x_fifo_wen, w_fifo_wen, x_fifo_ren, w_fifo_ren;
  logic [SZ-1:0] x_fifo_full, w_fifo_full, x_fifo_empty, w_fifo_empty;
  logic [1:0]    out_rsel, out_csel;

  int tests = 0;
  int fails = 0;

  // Hand-derived read-enable pattern for k = 0..10 (lane i on k=i..i+3).
  logic [SZ-1:0] ren_exp [0:10] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                    4'b1110, 4'b1100, 4'b1000, 4'b0000,
                                    4'b0000, 4'b0000, 4'b0000};

  always #5 clk = ~clk;

  systolic_ctrl #(.size(SZ)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy),
    .x_fifo_wen(x_fifo_wen), .w_fifo_wen(w_fifo_wen),
    .x_fifo_ren(x_fifo_ren), .w_fifo_ren(w_fifo_ren),
    .x_fifo_full(x_fifo_full), .w_fifo_full(w_fifo_full),
    .x_fifo_empty(x_fifo_empty), .w_fifo_empty(w_fifo_empty),
    .mac_en(mac_en), .acc_clr(acc_clr),
    .out_rsel(out_rsel), .out_csel(out_csel),
    .out_val(out_val), .out_rdy(out_rdy), .busy(busy), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {9'd0, in_rdy, x_fifo_wen, w_fifo_wen, x_fifo_ren, w_fifo_ren,
            mac_en, acc_clr, out_rsel, out_csel, out_val, busy, err};
  endfunction

  task automatic load_job();
    for (int b = 0; b < SZ; b++) begin
      in_val = 1'b1;
      settle();
      check("load_in_rdy", in_rdy, 1);
      check("load_busy", busy, 0);
      check("load_wen", {x_fifo_wen, w_fifo_wen}, 8'hFF);
      next();
    end
    in_val = 1'b0;
  endtask

  task automatic compute_window(input bit hold_val);
    int rd_x0, rd_x3;
    rd_x0 = 0;
    rd_x3 = 0;
    for (int k = 0; k < 3*SZ-1; k++) begin
      in_val = hold_val;
      settle();
      check("cmp_mac_en", mac_en, 1);
      check("cmp_in_rdy", in_rdy, 0);
      check("cmp_busy", busy, 1);
      check("cmp_wen", {x_fifo_wen, w_fifo_wen}, 8'h00);
      check("cmp_x_ren", x_fifo_ren, ren_exp[k]);
      check("cmp_w_ren", w_fifo_ren, ren_exp[k]);
      rd_x0 += int'(x_fifo_ren[0]);
      rd_x3 += int'(x_fifo_ren[3]);
      next();
    end
    in_val = 1'b0;
    check("cmp_reads_lane0", rd_x0, 4);
    check("cmp_reads_lane3", rd_x3, 4);
  endtask

  task automatic output_stream();
    for (int n = 0; n < SZ*SZ; n++) begin
      out_rdy = 1'b1;
      settle();
      check("out_val", out_val, 1);
      check("out_rsel", out_rsel, n / SZ);
      check("out_csel", out_csel, n % SZ);
      check("out_mac_en", mac_en, 0);
      next();
    end
    out_rdy = 1'b0;
    settle();
    check("clr_pulse", acc_clr, 1);
    check("clr_out_val", out_val, 0);
    check("clr_in_rdy", in_rdy, 0);
    next();
    settle();
    check("post_clr_in_rdy", in_rdy, 1);
    check("post_clr_acc_clr", acc_clr, 0);
    check("post_clr_busy", busy, 0);
    check("post_clr_sel", {out_rsel, out_csel}, 0);
    next();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc, accepts;
    rst = 1'b1;
    in_val = 1'b1;
    out_rdy = 1'b1;
    x_fifo_full = '0;
    w_fifo_full = '0;
    x_fifo_empty = '0;
    w_fifo_empty = '0;

    // Reset: every output forced low even with in_val/out_rdy high.
    next();
    settle();
    check("rst_outs", all_outs(), 0);
    next();
    settle();
    check("rst_outs2", all_outs(), 0);
    next();
    rst = 1'b0;
    in_val = 1'b0;
    out_rdy = 1'b0;
    settle();
    check("rel_in_rdy", in_rdy, 1);
    check("rel_busy", busy, 0);
    check("rel_err", err, 0);
    check("rel_sel", {out_rsel, out_csel}, 0);
    next();

    // 1-3: back-to-back load, compute with in_val held high, full stream.
    load_job();
    compute_window(1'b1);
    output_stream();

    // 4: out_rdy pattern 1,0,0 repeating.
    load_job();
    compute_window(1'b0);
    n = 0;
    cyc = 0;
    accepts = 0;
    while (n < SZ*SZ && cyc < 100) begin
      out_rdy = (cyc % 3 == 0);
      settle();
      check("stall_out_val", out_val, 1);
      check("stall_sel", {out_rsel, out_csel}, n);
      if (out_rdy) begin
        n++;
        accepts++;
      end
      cyc++;
      next();
    end
    out_rdy = 1'b0;
    check("stall_accepts", accepts, 16);
    check("stall_cycles", cyc, 46);
    settle();
    check("stall_clr", acc_clr, 1);
    next();
    settle();
    check("stall_post_in_rdy", in_rdy, 1);
    next();

    // 5: reset during the 7th output beat.
    load_job();
    compute_window(1'b0);
    for (int b = 0; b < 6; b++) begin
      out_rdy = 1'b1;
      settle();
      check("mid_sel", {out_rsel, out_csel}, b);
      next();
    end
    rst = 1'b1;
    settle();
    check("mid_rst_outs", all_outs(), 0);
    next();
    settle();
    check("mid_rst_outs_next", all_outs(), 0);
    next();
    rst = 1'b0;
    out_rdy = 1'b0;
    settle();
    check("mid_rel_in_rdy", in_rdy, 1);
    check("mid_rel_busy", busy, 0);
    check("mid_rel_sel", {out_rsel, out_csel}, 0);
    check("mid_rel_out_val", out_val, 0);
    next();

    // 6: x_fifo_empty[2] tied high across COMPUTE.
    load_job();
    for (int k = 0; k < 3*SZ-1; k++) begin
      x_fifo_empty = 4'b0100;
      settle();
      check("err_k", err, (k >= 2) ? 1 : 0);
      next();
    end
    x_fifo_empty = '0;
    output_stream();
    settle();
    check("err_sticky", err, 1);
    check("err_in_rdy", in_rdy, 1);
    next();
    rst = 1'b1;
    settle();
    check("err_rst", err, 0);
    next();
    rst = 1'b0;
    settle();
    check("err_cleared", err, 0);
    next();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
